moore_t_fsm: RTL and testbench
==============================

Name: moore_t_fsm

Overview:
- Moore-type serial sequence detector for the pattern 1011 on a 1-bit input stream.
- State register built from T flip-flops: each state bit toggles when its T input is 1.
- Output z is decoded from the current state only.
- Used as a small control/detect block and as a T-FF state-machine reference design.

Parameters:
- OVERLAP, 1, 1 = overlapping detection (pattern suffix reused after a match); 0 = restart after each match.
- CNT_W, 8, width of the saturating match counter (optional feature only).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset, sampled on the rising clk edge.
- x  input  1  serial data bit, sampled every rising clk edge.
- z  output  1  detect flag; 1 while the FSM is in state S4.
- state  output  3  current state encoding, for debug.
- match_count  output  CNT_W  number of detections; present only with the optional feature.

Behaviour:
- Clocking: one clock. Reset is synchronous and active-high.
- State encoding (binary, 3 bits): S0=000 idle, S1=001 "1", S2=010 "10", S3=011 "101", S4=100 "1011" detected.
- State register: three T flip-flops with T[i] = cur[i] XOR next[i]. The registered state must equal a plain D-register implementation of the same next-state logic.
- Transitions, written as x=0 / x=1:
  - S0 -> S0 / S1
  - S1 -> S2 / S1
  - S2 -> S0 / S3
  - S3 -> S2 / S4
  - S4 with OVERLAP=1 -> S2 / S1
  - S4 with OVERLAP=0 -> S0 / S1
- Illegal encodings 101, 110, 111 go to S0 on the next edge regardless of x; z=0 while in them.
- Output: z = 1 iff state == S4. z is combinational from state only, never from x.
- Latency: z asserts for exactly one cycle, starting on the rising edge that samples the final 1 of 1011. It lasts longer only if a new match completes immediately, which is impossible with a 4-bit pattern, so z is never high on consecutive cycles.
- Reset:
  - reset=1 at a rising edge forces S0 next cycle, so z=0 and state=000.
  - Reset has priority over x and over any state.
  - Reset mid-pattern (for example in S3) discards partial progress.
- Before the first reset edge, state is undefined. Implementation must not rely on initial blocks.

Optional Feature:
- Macro: MOORE_T_COUNT_EN.
- When defined:
  - Adds output match_count[CNT_W-1:0].
  - Increments by 1 on every rising edge where the next state is S4.
  - Saturates at all-ones and does not wrap.
  - Cleared to 0 by reset.
- When not defined: no match_count port and no counter logic; all other behaviour is identical.

Test Plan:
- Reset: reset=1 for one edge with x=0 -> state=000, z=0; with the counter enabled, match_count=0.
- Basic detect: after reset, x sequence 0,1,0,1,1,0,1,1 on successive edges -> state S0,S1,S2,S3,S4,S2,S3,S4. z=1 only after the 5th and 8th edges; match_count=2.
- Non-overlap (OVERLAP=0): x = 1,0,1,1,0,1,1 -> z=1 only after the 4th edge, with S4 -> S0 after the 5th edge. OVERLAP=1 gives z=1 after both the 4th and 7th edges.
- No false detect: x = 1,1,1,1,0,0,1,0,0 -> z stays 0 throughout; state never reaches 100.
- Reset mid-pattern: x=1,0,1 reaching S3, then reset=1 with x=1 for one edge -> state=000 and z=0, not S4. Then 1,0,1,1 -> z=1 after the 4th edge.
- Illegal state / saturation: force state=111 -> next edge goes to S0, z=0. With CNT_W=2, five matches -> match_count=3.

Source files
------------

// File: rtl/moore_t_fsm.sv
// -----------------------------------------------------------------------------
// moore_t_fsm
//
// Moore serial sequence detector for the bit pattern 1011. The state register
// is three T flip-flops: each bit toggles when its T input is 1, and
// T = cur ^ next. That makes the registered state identical to a plain
// D-register driven by the same next-state logic.
//
// The detect flag z is decoded from the current state only, never from x.
// z is high for exactly one cycle after the edge that samples the final 1.
//
// Parameters:
//   OVERLAP : 1 = after a match, the "10" suffix is reused (S4 -x=0-> S2)
//             0 = after a match, detection restarts (S4 -x=0-> S0)
//   CNT_W   : width of the saturating match counter (optional feature)
//
// Optional feature (macro MOORE_T_COUNT_EN):
//   Adds output match_count. It increments on every edge whose next state is
//   S4, saturates at all-ones, and is cleared by reset.
//
// Ports:
//   clk         in   system clock, rising edge
//   reset       in   synchronous active-high reset
//   x           in   serial data bit
//   z           out  detect flag, 1 while in S4
//   state       out  current 3-bit state encoding (debug)
//   match_count out  [CNT_W-1:0] detection count (MOORE_T_COUNT_EN only)
// -----------------------------------------------------------------------------
module moore_t_fsm #(
  parameter int OVERLAP = 1,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             x,
  output logic             z,
  output logic [2:0]       state
`ifdef MOORE_T_COUNT_EN
  ,
  output logic [CNT_W-1:0] match_count
`endif
);

  typedef enum logic [2:0] {
    S0 = 3'b000,  // idle
    S1 = 3'b001,  // seen "1"
    S2 = 3'b010,  // seen "10"
    S3 = 3'b011,  // seen "101"
    S4 = 3'b100   // seen "1011"
  } state_e;

  // A zero-width counter is meaningless, so catch it at elaboration.
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("moore_t_fsm: CNT_W must be at least 1");
  end

  logic [2:0] state_q;     // T flip-flop outputs
  logic [2:0] next_state;  // next state the transition table asks for
  logic [2:0] t;           // toggle enables, one per state bit

  // Next-state logic. Illegal encodings (101, 110, 111) fall into the default
  // and return to S0 whatever x is.
  // NOTE: next_state is assigned first, before the case, so every path
  // through the block drives it and no latch is inferred.
  always_comb begin
    next_state = S0;
    case (state_q)
      S0:      next_state = x ? S1 : S0;
      S1:      next_state = x ? S1 : S2;
      S2:      next_state = x ? S3 : S0;
      S3:      next_state = x ? S4 : S2;
      S4: begin
        if (x)                next_state = S1;
        else if (OVERLAP != 0) next_state = S2;
        else                  next_state = S0;
      end
      default: next_state = S0;
    endcase
  end

  // A T flip-flop toggles exactly the bits that must change.
  assign t = state_q ^ next_state;

  // State register, plus the optional counter. Reset is synchronous and
  // takes priority over x and over the current state.
  // NOTE: sequential state uses non-blocking assignments, so every flop
  // samples values from before the clock edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S0;
    end else begin
      state_q <= state_q ^ t;
    end
  end

`ifdef MOORE_T_COUNT_EN
  // Counts edges that enter S4. It holds at all-ones instead of wrapping, so
  // a saturated value means "at least this many".
  always_ff @(posedge clk) begin
    if (reset) begin
      match_count <= '0;
    end else if ((next_state == S4) && (match_count != '1)) begin
      match_count <= match_count + CNT_W'(1);
    end
  end
`endif

  // Moore outputs: functions of the state register only.
  assign z     = (state_q == S4);
  assign state = state_q;

endmodule

// File: tb/tb_moore_t_fsm.sv
// -----------------------------------------------------------------------------
// tb_moore_t_fsm
//
// Runs two instances side by side: one with OVERLAP=1 (CNT_W=2, so its
// counter saturates quickly) and one with OVERLAP=0 (CNT_W=8).
//
// The test has four parts:
//   1. A table of directed vectors with hand-derived expected states.
//   2. Hand-written sequences for counter saturation and for the illegal
//      encodings, which are forced into the state register.
//   3. Random stimulus checked against a reference model. The model keeps the
//      recent input history and reports the longest prefix of 1011 that is a
//      suffix of that history. In non-overlapping mode, the history is cleared
//      once a match has been reported.
//   4. A single summary line.
//
// Inputs are driven on the falling edge. Outputs are sampled 1 time unit
// after the rising edge.
// -----------------------------------------------------------------------------
module tb_moore_t_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic       x;
  logic       z_ov, z_no;
  logic [2:0] state_ov, state_no;
`ifdef MOORE_T_COUNT_EN
  logic [1:0] cnt_ov;
  logic [7:0] cnt_no;
`endif

  always #5 clk = ~clk;

  moore_t_fsm #(.OVERLAP(1), .CNT_W(2)) dut_ov (
    .clk         (clk),
    .reset       (reset),
    .x           (x),
    .z           (z_ov),
    .state       (state_ov)
`ifdef MOORE_T_COUNT_EN
    ,
    .match_count (cnt_ov)
`endif
  );

  moore_t_fsm #(.OVERLAP(0), .CNT_W(8)) dut_no (
    .clk         (clk),
    .reset       (reset),
    .x           (x),
    .z           (z_no),
    .state       (state_no)
`ifdef MOORE_T_COUNT_EN
    ,
    .match_count (cnt_no)
`endif
  );

  int vectors    = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef bit bitq_t[$];
  bit    pat [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
  bitq_t h_ov, h_no;
  int    c_ov, c_no;

  // Length of the longest prefix of 1011 that ends the history.
  function automatic int plen(bitq_t q);
    for (int k = 4; k >= 1; k--) begin
      if (q.size() >= k) begin
        bit ok = 1'b1;
        for (int i = 0; i < k; i++)
          if (q[q.size() - k + i] != pat[i]) ok = 1'b0;
        if (ok) return k;
      end
    end
    return 0;
  endfunction

  function automatic bitq_t adv(bit ov, bit xv, bitq_t q);
    bitq_t r = q;
    if (!ov && plen(r) == 4) r.delete();
    r.push_back(xv);
    if (r.size() > 4) void'(r.pop_front());
    return r;
  endfunction

  // Applies one clock edge and advances the model to match.
  task automatic step(input bit r, input bit xv);
    @(negedge clk);
    reset = r;
    x     = xv;
    @(posedge clk);
    #1;
    if (r) begin
      h_ov.delete();
      h_no.delete();
      c_ov = 0;
      c_no = 0;
    end else begin
      h_ov = adv(1'b1, xv, h_ov);
      h_no = adv(1'b0, xv, h_no);
      if (plen(h_ov) == 4 && c_ov < 3)   c_ov++;
      if (plen(h_no) == 4 && c_no < 255) c_no++;
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, " ov state"}, 32'(state_ov), 32'(plen(h_ov)));
    check({tag, " ov z"},     32'(z_ov),     32'(plen(h_ov) == 4));
    check({tag, " no state"}, 32'(state_no), 32'(plen(h_no)));
    check({tag, " no z"},     32'(z_no),     32'(plen(h_no) == 4));
`ifdef MOORE_T_COUNT_EN
    check({tag, " ov cnt"},   32'(cnt_ov),   32'(c_ov));
    check({tag, " no cnt"},   32'(cnt_no),   32'(c_no));
`endif
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    bit r;
    bit x;
    int s_ov;
    int s_no;
    int c_ov;
    int c_no;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit r, input bit xv, input int sov, input int sno,
                     input int cov, input int cno);
    vec_t v;
    v.r    = r;
    v.x    = xv;
    v.s_ov = sov;
    v.s_no = sno;
    v.c_ov = cov;
    v.c_no = cno;
    tbl.push_back(v);
  endtask

  initial begin
    reset = 1'b1;
    x     = 1'b0;

    // Basic detect: 0,1,0,1,1,0,1,1
    add(1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0);
    add(0, 1, 1, 1, 0, 0);
    add(0, 0, 2, 2, 0, 0);
    add(0, 1, 3, 3, 0, 0);
    add(0, 1, 4, 4, 1, 1);
    add(0, 0, 2, 0, 1, 1);
    add(0, 1, 3, 1, 1, 1);
    add(0, 1, 4, 1, 2, 1);

    // Overlap vs restart: 1,0,1,1,0,1,1
    add(1, 0, 0, 0, 0, 0);
    add(0, 1, 1, 1, 0, 0);
    add(0, 0, 2, 2, 0, 0);
    add(0, 1, 3, 3, 0, 0);
    add(0, 1, 4, 4, 1, 1);
    add(0, 0, 2, 0, 1, 1);
    add(0, 1, 3, 1, 1, 1);
    add(0, 1, 4, 1, 2, 1);

    // No false detect: 1,1,1,1,0,0,1,0,0
    add(1, 0, 0, 0, 0, 0);
    add(0, 1, 1, 1, 0, 0);
    add(0, 1, 1, 1, 0, 0);
    add(0, 1, 1, 1, 0, 0);
    add(0, 1, 1, 1, 0, 0);
    add(0, 0, 2, 2, 0, 0);
    add(0, 0, 0, 0, 0, 0);
    add(0, 1, 1, 1, 0, 0);
    add(0, 0, 2, 2, 0, 0);
    add(0, 0, 0, 0, 0, 0);

    // Reset from S3 with x=1 must not reach S4; then 1,0,1,1 detects.
    add(1, 0, 0, 0, 0, 0);
    add(0, 1, 1, 1, 0, 0);
    add(0, 0, 2, 2, 0, 0);
    add(0, 1, 3, 3, 0, 0);
    add(1, 1, 0, 0, 0, 0);
    add(0, 1, 1, 1, 0, 0);
    add(0, 0, 2, 2, 0, 0);
    add(0, 1, 3, 3, 0, 0);
    add(0, 1, 4, 4, 1, 1);

    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].x);
      check($sformatf("tbl[%0d] ov state", i), 32'(state_ov), 32'(tbl[i].s_ov));
      check($sformatf("tbl[%0d] ov z", i),     32'(z_ov),     32'(tbl[i].s_ov == 4));
      check($sformatf("tbl[%0d] no state", i), 32'(state_no), 32'(tbl[i].s_no));
      check($sformatf("tbl[%0d] no z", i),     32'(z_no),     32'(tbl[i].s_no == 4));
`ifdef MOORE_T_COUNT_EN
      check($sformatf("tbl[%0d] ov cnt", i),   32'(cnt_ov),   32'(tbl[i].c_ov));
      check($sformatf("tbl[%0d] no cnt", i),   32'(cnt_no),   32'(tbl[i].c_no));
`endif
    end

    // Five back-to-back 1011 patterns: both modes detect each one. The 2-bit
    // counter saturates at 3; the 8-bit counter reaches 5.
    step(1'b1, 1'b0);
    for (int m = 0; m < 5; m++) begin
      step(1'b0, 1'b1);
      step(1'b0, 1'b0);
      step(1'b0, 1'b1);
      step(1'b0, 1'b1);
      check($sformatf("sat match %0d ov z", m), 32'(z_ov), 32'd1);
      check($sformatf("sat match %0d no z", m), 32'(z_no), 32'd1);
    end
`ifdef MOORE_T_COUNT_EN
    check("sat ov cnt", 32'(cnt_ov), 32'd3);
    check("sat no cnt", 32'(cnt_no), 32'd5);
`endif

    // Illegal encodings: z=0 while in them. On the next edge they go to S0,
    // even with x=1.
    for (int v = 5; v <= 7; v++) begin
      @(negedge clk);
      reset = 1'b0;
      x     = 1'b1;
      force dut_ov.state_q = 3'(v);
      force dut_no.state_q = 3'(v);
      #1;
      check($sformatf("illegal %0d ov z", v), 32'(z_ov), 32'd0);
      check($sformatf("illegal %0d no z", v), 32'(z_no), 32'd0);
      release dut_ov.state_q;
      release dut_no.state_q;
      @(posedge clk);
      #1;
      check($sformatf("illegal %0d ov next", v), 32'(state_ov), 32'd0);
      check($sformatf("illegal %0d no next", v), 32'(state_no), 32'd0);
      h_ov.delete();
      h_no.delete();
`ifdef MOORE_T_COUNT_EN
      check($sformatf("illegal %0d ov cnt", v), 32'(cnt_ov), 32'(c_ov));
      check($sformatf("illegal %0d no cnt", v), 32'(cnt_no), 32'(c_no));
`endif
    end

    // Random stimulus against the reference model: occasional resets, and a
    // bias toward 1s so that matches are common.
    step(1'b1, 1'b0);
    check_model("rnd reset");
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 39) == 0), ($urandom_range(0, 9) < 6));
      check_model($sformatf("rnd[%0d]", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
